// File: rtl/fridge_zone_controller.sv
// Multi-zone refrigerator controller: per-zone door tracking, door-open alarm,
// hysteretic thermostat and compressor min-on/min-off protection.

module fridge_zone #(
  parameter int TEMP_W      = 8,
  parameter int HYST        = 2,
  parameter int MIN_ON_CYC  = 8,
  parameter int MIN_OFF_CYC = 16,
  parameter int ALARM_CYC   = 32,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     door_open_p,
  input  logic                     door_close_p,
  input  logic signed [TEMP_W-1:0] temp,
  input  logic                     temp_valid,
  input  logic signed [TEMP_W-1:0] setpoint,
  input  logic                     alarm_ack,
  output logic                     door_state,
  output logic                     cooling,
  output logic                     alarm,
  output logic                     alarm_nxt
);

  typedef enum logic [1:0] {OFF_LOCK, OFF_READY, ON_LOCK, ON_READY} state_t;

  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] ALARM_MAX = CNT_W'(ALARM_CYC);
  localparam logic signed [TEMP_W:0] HYST_X = (TEMP_W+1)'(HYST);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         tmr_q, tmr_d;
  logic [CNT_W-1:0]         acnt_q, acnt_d;
  logic                     door_q, door_d;
  logic                     seen_q, seen_d;
  logic                     alarm_q, alarm_d;
  logic signed [TEMP_W-1:0] temp_q, temp_d;
  logic signed [TEMP_W:0]   temp_x, hi_x, lo_x;
  logic                     hot, cold;

  // One extra bit keeps setpoint +/- HYST exact at the signed extremes.
  always_comb begin
    temp_x = {temp_q[TEMP_W-1], temp_q};
    hi_x   = {setpoint[TEMP_W-1], setpoint} + HYST_X;
    lo_x   = {setpoint[TEMP_W-1], setpoint} - HYST_X;
    hot    = temp_x > hi_x;
    cold   = temp_x <= lo_x;
  end

  always_comb begin
    door_d = door_open_p | (door_q & ~door_close_p);
    temp_d = temp_valid ? temp : temp_q;
    seen_d = seen_q | temp_valid;

    acnt_d = acnt_q;
    if (!door_q || alarm_ack)   acnt_d = '0;
    else if (acnt_q != ALARM_MAX) acnt_d = acnt_q + CNT_W'(1);
    alarm_d = (acnt_d == ALARM_MAX);
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      OFF_LOCK: begin
        if (tmr_q == '0) state_d = OFF_READY;
        else             tmr_d   = tmr_q - CNT_W'(1);
      end
      OFF_READY: begin
        if (seen_q && hot && !door_q) begin
          state_d = ON_LOCK;
          tmr_d   = ON_LOAD;
        end
      end
      ON_LOCK: begin
        if (tmr_q == '0) state_d = ON_READY;
        else             tmr_d   = tmr_q - CNT_W'(1);
      end
      ON_READY: begin
        if (cold || door_q) begin
          state_d = OFF_LOCK;
          tmr_d   = OFF_LOAD;
        end
      end
      default: begin
        state_d = OFF_LOCK;
        tmr_d   = OFF_LOAD;
      end
    endcase
  end

  // Reset lands in OFF_LOCK so the compressor rests after power restore.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OFF_LOCK;
      tmr_q   <= OFF_LOAD;
      acnt_q  <= '0;
      door_q  <= 1'b0;
      seen_q  <= 1'b0;
      alarm_q <= 1'b0;
      temp_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      acnt_q  <= acnt_d;
      door_q  <= door_d;
      seen_q  <= seen_d;
      alarm_q <= alarm_d;
      temp_q  <= temp_d;
    end
  end

  assign door_state = door_q;
  assign cooling    = (state_q == ON_LOCK) || (state_q == ON_READY);
  assign alarm      = alarm_q;
  assign alarm_nxt  = alarm_d;

endmodule

module fridge_zone_controller #(
  parameter int NUM_ZONES   = 2,
  parameter int TEMP_W      = 8,
  parameter int HYST        = 2,
  parameter int MIN_ON_CYC  = 8,
  parameter int MIN_OFF_CYC = 16,
  parameter int ALARM_CYC   = 32,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_ZONES-1:0]          door_open_p,
  input  logic [NUM_ZONES-1:0]          door_close_p,
  input  logic [NUM_ZONES*TEMP_W-1:0]   temp,
  input  logic [NUM_ZONES-1:0]          temp_valid,
  input  logic [NUM_ZONES*TEMP_W-1:0]   setpoint,
  input  logic [NUM_ZONES-1:0]          alarm_ack,
  output logic [NUM_ZONES-1:0]          door_state,
  output logic [NUM_ZONES-1:0]          cooling,
  output logic [NUM_ZONES-1:0]          alarm,
  output logic                          any_alarm
);

  logic [NUM_ZONES-1:0] alarm_nxt;
  logic                 any_alarm_q, any_alarm_d;

  for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
    fridge_zone #(
      .TEMP_W      (TEMP_W),
      .HYST        (HYST),
      .MIN_ON_CYC  (MIN_ON_CYC),
      .MIN_OFF_CYC (MIN_OFF_CYC),
      .ALARM_CYC   (ALARM_CYC),
      .CNT_W       (CNT_W)
    ) u_zone (
      .clk          (clk),
      .reset_n      (reset_n),
      .door_open_p  (door_open_p[i]),
      .door_close_p (door_close_p[i]),
      .temp         (temp[i*TEMP_W +: TEMP_W]),
      .temp_valid   (temp_valid[i]),
      .setpoint     (setpoint[i*TEMP_W +: TEMP_W]),
      .alarm_ack    (alarm_ack[i]),
      .door_state   (door_state[i]),
      .cooling      (cooling[i]),
      .alarm        (alarm[i]),
      .alarm_nxt    (alarm_nxt[i])
    );
  end

  // Built from the per-zone next-state so it changes on the same edge as alarm.
  always_comb any_alarm_d = |alarm_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_alarm_q <= 1'b0;
    else          any_alarm_q <= any_alarm_d;
  end

  assign any_alarm = any_alarm_q;

endmodule

// File: tb/tb_fridge_zone_controller.sv
// Directed bench for fridge_zone_controller (2 zones, default timing).

module tb_fridge_zone_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  door_open_p, door_close_p, temp_valid, alarm_ack;
  logic [15:0] temp, setpoint;
  logic [1:0]  door_state, cooling, alarm;
  logic        any_alarm;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fridge_zone_controller #(
    .NUM_ZONES(2), .TEMP_W(8), .HYST(2), .MIN_ON_CYC(8),
    .MIN_OFF_CYC(16), .ALARM_CYC(32), .CNT_W(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .door_open_p  (door_open_p),
    .door_close_p (door_close_p),
    .temp         (temp),
    .temp_valid   (temp_valid),
    .setpoint     (setpoint),
    .alarm_ack    (alarm_ack),
    .door_state   (door_state),
    .cooling      (cooling),
    .alarm        (alarm),
    .any_alarm    (any_alarm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b1;
    door_open_p  = '0;
    door_close_p = '0;
    alarm_ack    = '0;
    temp_valid   = 2'b11;
    temp         = {8'hEC, 8'd10};   // zone1 -20, zone0 10
    setpoint     = {8'hEE, 8'd4};    // zone1 -18, zone0 4
    #1 reset_n = 1'b0;
    #11;
    chk("rst_door", 32'(door_state), 32'h0);
    chk("rst_cool", 32'(cooling), 32'h0);
    chk("rst_alarm", 32'(alarm), 32'h0);
    chk("rst_any", 32'(any_alarm), 32'h0);

    // 1: power-up OFF_LOCK holds for 16 cycles
    tick(); reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); chk("t1_lock", 32'(cooling[0]), 32'h0);
    end
    tick();
    chk("t1_on", 32'(cooling[0]), 32'h1);
    chk("t1_z1_off", 32'(cooling[1]), 32'h0);

    // 2: cold during ON_LOCK does not abort min-on
    for (int i = 1; i <= 8; i++) begin
      tick(); chk("t2_minon", 32'(cooling[0]), 32'h1);
      if (i == 3) temp[7:0] = 8'd2;
    end
    tick(); chk("t2_off", 32'(cooling[0]), 32'h0);
    temp[7:0] = 8'd10;
    for (int i = 0; i < 16; i++) begin
      tick(); chk("t2_minoff", 32'(cooling[0]), 32'h0);
    end
    tick(); chk("t2_reon", 32'(cooling[0]), 32'h1);

    // 3: door in ON_READY, alarm, snooze, close
    tick(8);
    door_open_p = 2'b01;
    tick();
    chk("t3_door", 32'(door_state[0]), 32'h1);
    chk("t3_cool_hold", 32'(cooling[0]), 32'h1);
    door_open_p = 2'b00;
    tick();
    chk("t3_cool_off", 32'(cooling[0]), 32'h0);
    chk("t3_alarm0", 32'(alarm[0]), 32'h0);
    tick(17);
    door_open_p = 2'b01;             // redundant open
    tick();
    door_open_p = 2'b00;
    chk("t3_redund", 32'(door_state[0]), 32'h1);
    tick(12);
    chk("t3_pre_alarm", 32'(alarm[0]), 32'h0);
    chk("t3_pre_any", 32'(any_alarm), 32'h0);
    tick();
    chk("t3_alarm", 32'(alarm[0]), 32'h1);
    chk("t3_any", 32'(any_alarm), 32'h1);
    alarm_ack = 2'b01;
    tick();
    alarm_ack = 2'b00;
    chk("t3_ack", 32'(alarm[0]), 32'h0);
    chk("t3_ack_any", 32'(any_alarm), 32'h0);
    tick(31);
    chk("t3_snooze", 32'(alarm[0]), 32'h0);
    tick();
    chk("t3_realarm", 32'(alarm[0]), 32'h1);
    door_close_p = 2'b01;
    tick();
    door_close_p = 2'b00;
    chk("t3_closed", 32'(door_state[0]), 32'h0);
    chk("t3_alarm_lag", 32'(alarm[0]), 32'h1);
    tick();
    chk("t3_alarm_clr", 32'(alarm[0]), 32'h0);
    chk("t3_any_clr", 32'(any_alarm), 32'h0);
    chk("t3_cool_back", 32'(cooling[0]), 32'h1);

    // 4: open wins over close; close while closed is a no-op
    door_open_p = 2'b01; door_close_p = 2'b01;
    tick();
    chk("t4_both", 32'(door_state[0]), 32'h1);
    chk("t4_onlock", 32'(cooling[0]), 32'h1);
    door_open_p = 2'b00;
    tick();
    chk("t4_close", 32'(door_state[0]), 32'h0);
    tick();
    chk("t4_close2", 32'(door_state[0]), 32'h0);
    door_close_p = 2'b00;
    chk("t4_z1_door", 32'(door_state[1]), 32'h0);
    chk("t4_z1_cool", 32'(cooling[1]), 32'h0);
    chk("t4_z1_alarm", 32'(alarm[1]), 32'h0);

    // 5: signed extremes; zone1 door opened to build an alarm for step 6
    temp[7:0] = 8'h80; setpoint[7:0] = 8'h7F;
    door_open_p = 2'b10;
    tick();
    door_open_p = 2'b00;
    chk("t5_z1_door", 32'(door_state), 32'h2);
    tick(5);
    chk("t5_off", 32'(cooling[0]), 32'h0);
    tick(22);
    chk("t5_never_hot", 32'(cooling[0]), 32'h0);
    temp[7:0] = 8'h7F; setpoint[7:0] = 8'h80;
    tick();
    chk("t5_lat", 32'(cooling[0]), 32'h0);
    tick();
    chk("t5_hot_on", 32'(cooling[0]), 32'h1);
    chk("t5_z1_cool", 32'(cooling[1]), 32'h0);
    tick(2);
    chk("t5_z1_pre", 32'(alarm[1]), 32'h0);
    tick();
    chk("t5_z1_alarm", 32'(alarm[1]), 32'h1);
    chk("t5_any", 32'(any_alarm), 32'h1);
    chk("t5_onlock", 32'(cooling[0]), 32'h1);

    // 6: mid-cycle async reset, then protection hold again
    #3 reset_n = 1'b0;
    #1;
    chk("t6_cool", 32'(cooling), 32'h0);
    chk("t6_alarm", 32'(alarm), 32'h0);
    chk("t6_door", 32'(door_state), 32'h0);
    chk("t6_any", 32'(any_alarm), 32'h0);
    tick(); reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); chk("t6_lock", 32'(cooling[0]), 32'h0);
    end
    tick();
    chk("t6_on", 32'(cooling[0]), 32'h1);
    chk("t6_z1_cool", 32'(cooling[1]), 32'h0);
    chk("t6_z1_alarm", 32'(alarm[1]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
